// File: rtl/uart_rx_word_packer.sv
// Packs pairs of received UART bytes into 16-bit FIFO words, dropping when the FIFO is full.
// Optional lone-byte timeout flush is built only when UART_PACK_TIMEOUT_EN is defined.
module uart_rx_word_packer #(
  parameter bit          HI_FIRST     = 1'b1,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        wr_full,
  input  logic        clr_ovf,
  output logic [15:0] wr_data,
  output logic        wr_req,
  output logic        pending,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HALF = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_req_q, wr_req_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;

  logic        emit;
  logic        drop;
  logic [15:0] word;
  logic        timeout_hit;

  function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
    return HI_FIRST ? {first, second} : {second, first};
  endfunction

`ifdef UART_PACK_TIMEOUT_EN
  localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CLKS - 1);

  logic [19:0] timer_q, timer_d;

  assign timeout_hit = (state_q == ST_HALF) && (timer_q == TIMER_LAST);

  always_comb begin
    timer_d = timer_q;
    if (state_q == ST_IDLE) begin
      if (rx_valid) timer_d = '0;
    end else if (!rx_valid && !timeout_hit) begin
      timer_d = timer_q + 20'd1;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  // Without the timer a lone byte simply waits for its partner.
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    emit    = 1'b0;
    word    = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          hold_d  = rx_data;
          state_d = ST_HALF;
        end
      end
      default: begin
        // A real byte always beats the timeout in the same cycle.
        if (rx_valid) begin
          word    = pack(hold_q, rx_data);
          emit    = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          word    = pack(hold_q, PAD_BYTE);
          emit    = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign drop      = emit && wr_full;
  assign wr_req_d  = emit && !wr_full;
  assign wr_data_d = wr_req_d ? word : wr_data_q;

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      // A drop coinciding with a clear restarts the count at one.
      ovf_d  = 1'b1;
      if (clr_ovf)               drop_d = 8'd1;
      else if (drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      hold_q    <= 8'h00;
      wr_data_q <= 16'h0000;
      wr_req_q  <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wr_data_q <= wr_data_d;
      wr_req_q  <= wr_req_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign wr_data  = wr_data_q;
  assign wr_req   = wr_req_q;
  assign pending  = (state_q == ST_HALF);
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: one HI_FIRST=1 and one HI_FIRST=0 instance share stimulus.
module tb_uart_rx_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_full;
  logic        clr_ovf;

  logic [15:0] hi_data, lo_data;
  logic        hi_req, lo_req, hi_pend, lo_pend, hi_ovf, lo_ovf;
  logic [7:0]  hi_drop, lo_drop;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_word_packer #(.HI_FIRST(1'b1), .PAD_BYTE(8'h00), .TIMEOUT_CLKS(16)) u_hi (
    .SYS_CLK(clk), .RST(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_full(wr_full), .clr_ovf(clr_ovf), .wr_data(hi_data), .wr_req(hi_req),
    .pending(hi_pend), .overflow(hi_ovf), .drop_cnt(hi_drop)
  );

  uart_rx_word_packer #(.HI_FIRST(1'b0), .PAD_BYTE(8'hEE), .TIMEOUT_CLKS(16)) u_lo (
    .SYS_CLK(clk), .RST(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_full(wr_full), .clr_ovf(clr_ovf), .wr_data(lo_data), .wr_req(lo_req),
    .pending(lo_pend), .overflow(lo_ovf), .drop_cnt(lo_drop)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        full;
    logic        clr;
    logic        exp_req;
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
    logic        exp_pend;
    logic        exp_ovf;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic c);
    rx_valid = v;
    rx_data  = d;
    wr_full  = f;
    clr_ovf  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_both(input string name, input logic req, input logic [15:0] ehi,
                          input logic [15:0] elo, input logic pend);
    chk({name, " hi_req"}, 32'(hi_req), 32'(req));
    chk({name, " lo_req"}, 32'(lo_req), 32'(req));
    chk({name, " hi_data"}, 32'(hi_data), 32'(ehi));
    chk({name, " lo_data"}, 32'(lo_data), 32'(elo));
    chk({name, " hi_pend"}, 32'(hi_pend), 32'(pend));
    chk({name, " lo_pend"}, 32'(lo_pend), 32'(pend));
  endtask

  initial begin
    int bad_req;
    int bad_pend;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; wr_full = 1'b0; clr_ovf = 1'b0;

    //               v     d      full  clr   req   hi        lo        pend  ovf   drop
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h3412, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h3412, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 16'h5678, 16'h7856, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h5678, 16'h7856, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 16'h5678, 16'h7856, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 16'h5678, 16'h7856, 1'b0, 1'b1, 8'd1});
    vecs.push_back('{1'b1, 8'hCC, 1'b1, 1'b0, 1'b0, 16'h5678, 16'h7856, 1'b1, 1'b1, 8'd1});
    vecs.push_back('{1'b1, 8'hDD, 1'b1, 1'b1, 1'b0, 16'h5678, 16'h7856, 1'b0, 1'b1, 8'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h5678, 16'h7856, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 16'h5678, 16'h7856, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 8'hBC, 1'b0, 1'b0, 1'b1, 16'h9ABC, 16'hBC9A, 1'b0, 1'b0, 8'd0});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].full, vecs[i].clr);
      $display("vec %0d: v=%0b d=%h full=%0b clr=%0b -> req=%0b hi=%h lo=%h pend=%0b ovf=%0b drop=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].full, vecs[i].clr,
               hi_req, hi_data, lo_data, hi_pend, hi_ovf, hi_drop);
      chk_both($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_pend);
      chk($sformatf("vec%0d hi_ovf", i), 32'(hi_ovf), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d lo_ovf", i), 32'(lo_ovf), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d hi_drop", i), 32'(hi_drop), 32'(vecs[i].exp_drop));
      chk($sformatf("vec%0d lo_drop", i), 32'(lo_drop), 32'(vecs[i].exp_drop));
    end

    // Reset while a byte is held: the held byte must vanish.
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("rst_mid held", 32'(hi_pend), 32'd1);
    do_reset();
    chk_both("rst_mid after", 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    chk_both("rst_mid word", 1'b1, 16'h0102, 16'h0201, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_mid single pulse", 32'(hi_req), 32'd0);

    // Saturation of the drop counter with the FIFO held full.
    bad_req = 0;
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      if (hi_req || lo_req) bad_req++;
      step(1'b1, 8'(i + 1), 1'b1, 1'b0);
      if (hi_req || lo_req) bad_req++;
    end
    $display("saturation: ovf=%0b drop=%0d data=%h", hi_ovf, hi_drop, hi_data);
    chk("sat no wr_req", 32'(bad_req), 32'd0);
    chk("sat hi_ovf", 32'(hi_ovf), 32'd1);
    chk("sat lo_ovf", 32'(lo_ovf), 32'd1);
    chk("sat hi_drop", 32'(hi_drop), 32'd255);
    chk("sat lo_drop", 32'(lo_drop), 32'd255);
    chk("sat data kept", 32'(hi_data), 32'h0102);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr hi_ovf", 32'(hi_ovf), 32'd0);
    chk("clr hi_drop", 32'(hi_drop), 32'd0);
    chk("clr lo_drop", 32'(lo_drop), 32'd0);

`ifdef UART_PACK_TIMEOUT_EN
    // Lone byte flushed with padding after 16 cycles in HALF.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    bad_req = 0; bad_pend = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (hi_req || lo_req) bad_req++;
      if (!hi_pend || !lo_pend) bad_pend++;
    end
    chk("to wait no req", 32'(bad_req), 32'd0);
    chk("to wait pending", 32'(bad_pend), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    $display("timeout flush: req=%0b hi=%h lo=%h", hi_req, hi_data, lo_data);
    chk_both("to flush", 1'b1, 16'hA500, 16'hEEA5, 1'b0);

    // Partner arriving on the timeout cycle wins over padding.
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("to edge pending", 32'(hi_pend), 32'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    $display("timeout edge: req=%0b hi=%h lo=%h", hi_req, hi_data, lo_data);
    chk_both("to edge word", 1'b1, 16'h5A3C, 16'h3C5A, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_both("to edge idle", 1'b0, 16'h5A3C, 16'h3C5A, 1'b0);
`else
    // Long gap between the two bytes of a word.
    step(1'b1, 8'hAF, 1'b0, 1'b0);
    bad_req = 0; bad_pend = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (hi_req || lo_req) bad_req++;
      if (!hi_pend || !lo_pend) bad_pend++;
    end
    chk("gap no req", 32'(bad_req), 32'd0);
    chk("gap pending", 32'(bad_pend), 32'd0);
    step(1'b1, 8'h35, 1'b0, 1'b0);
    $display("gap word: req=%0b hi=%h lo=%h", hi_req, hi_data, lo_data);
    chk_both("gap word", 1'b1, 16'hAF35, 16'h35AF, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_both("gap idle", 1'b0, 16'hAF35, 16'h35AF, 1'b0);

    // Without the timeout a lone byte is held indefinitely.
    step(1'b1, 8'h77, 1'b0, 1'b0);
    bad_req = 0; bad_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (hi_req || lo_req) bad_req++;
      if (!hi_pend || !lo_pend) bad_pend++;
    end
    chk("hold no req", 32'(bad_req), 32'd0);
    chk("hold pending", 32'(bad_pend), 32'd0);
    chk("hold data kept", 32'(hi_data), 32'hAF35);
    step(1'b1, 8'h88, 1'b0, 1'b0);
    $display("hold word: req=%0b hi=%h lo=%h", hi_req, hi_data, lo_data);
    chk_both("hold word", 1'b1, 16'h7788, 16'h8877, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
